// File: rtl/if_id_stage.sv
// Fetch stage: PC register, instruction memory addressing and the IF/ID register.
// Redirects bubble IF/ID; saturating stall and flush counters are kept for debug.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             HDU_Stall,
    input  logic             HDU_IFIDHold,
    input  logic             Branch_Taken,
    input  logic [31:0]      Branch_Target,
    input  logic             Jump,
    input  logic [31:0]      Jump_Target,
    input  logic [31:0]      IMem_Instr,
    input  logic             IMem_Ready,
    output logic [31:0]      IMem_Addr,
    output logic [31:0]      PC,
    output logic [31:0]      IFID_Instr,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic [31:0]      IFID_AddressRs,
    output logic [31:0]      IFID_AddressRt,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pcplus4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_redirect;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic             w_stall_sat;
    logic             w_flush_sat;

    assign w_redirect  = Branch_Taken | Jump;
    assign w_target    = (Branch_Taken ? Branch_Target : Jump_Target) & ~32'h3;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_stall_sat = (r_stall_cnt == {CNT_W{1'b1}});
    assign w_flush_sat = (r_flush_cnt == {CNT_W{1'b1}});

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_pcplus4   <= '0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_redirect) begin
            r_pc      <= w_target;
            r_instr   <= '0;
            r_pcplus4 <= '0;
            r_valid   <= 1'b0;
            if (!w_flush_sat) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end else if (HDU_Stall) begin
            // PC is frozen, so reloading IF/ID here just refetches the same word
            if (!HDU_IFIDHold) begin
                r_instr   <= IMem_Instr;
                r_pcplus4 <= w_pc_plus4;
                r_valid   <= 1'b1;
            end
            if (!w_stall_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else if (!IMem_Ready) begin
            if (!HDU_IFIDHold) begin
                r_instr   <= '0;
                r_pcplus4 <= '0;
                r_valid   <= 1'b0;
            end
        end else begin
            r_pc <= w_pc_plus4;
            if (!HDU_IFIDHold) begin
                r_instr   <= IMem_Instr;
                r_pcplus4 <= w_pc_plus4;
                r_valid   <= 1'b1;
            end
        end
    end

    assign IMem_Addr      = r_pc;
    assign PC             = r_pc;
    assign IFID_Instr     = r_instr;
    assign IFID_PCPlus4   = r_pcplus4;
    assign IFID_Valid     = r_valid;
    // Bubbles carry a zero word, so the hazard unit sees register 0 here
    assign IFID_AddressRs = {27'b0, r_instr[25:21]};
    assign IFID_AddressRt = {27'b0, r_instr[20:16]};
    assign StallCount     = r_stall_cnt;
    assign FlushCount     = r_flush_cnt;

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage of the 5-stage pipeline: PC register, instruction-memory address generation and the IF/ID pipeline register.
- Directly upstream of the hazard detection unit. It feeds that unit IFID_AddressRs/IFID_AddressRt and consumes its PC-stall and IF/ID-hold outputs.
- Takes redirects from branch/jump resolution and bubbles the IF/ID register on them.
- Keeps saturating stall and flush counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the StallCount and FlushCount counters

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous reset, active-low
HDU_Stall  input  1  hazard unit PC-stall request (load-use): hold PC
HDU_IFIDHold  input  1  hazard unit IF/ID hold request
Branch_Taken  input  1  resolved taken branch
Branch_Target  input  32  branch target address
Jump  input  1  resolved jump
Jump_Target  input  32  jump target address
IMem_Instr  input  32  instruction read combinationally at IMem_Addr
IMem_Ready  input  1  instruction memory has valid data this cycle
IMem_Addr  output  32  equals PC
PC  output  32  current fetch PC
IFID_Instr  output  32  registered instruction
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  IF/ID holds a real instruction
IFID_AddressRs  output  32  zero-extended IFID_Instr[25:21]
IFID_AddressRt  output  32  zero-extended IFID_Instr[20:16]
StallCount  output  CNT_W  cycles spent stalled
FlushCount  output  CNT_W  redirects taken

Behaviour:
- **Reset (Rst_n=0, asynchronous):**
  - PC=RESET_PC.
  - IFID_Instr, IFID_PCPlus4, IFID_Valid, StallCount and FlushCount are all 0.
  - Rs/Rt therefore read 0.
  - Reset asserted mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- **Per-cycle priority on the rising edge, highest first:**
  1. Redirect: Branch_Taken | Jump.
     - Next PC = Branch_Target if Branch_Taken, otherwise Jump_Target. Branch wins when both are asserted.
     - Target bits [1:0] are forced to 0.
     - IF/ID loads a bubble: Instr=0, PCPlus4=0, Valid=0.
     - FlushCount increments.
     - Applies regardless of HDU_Stall, HDU_IFIDHold and IMem_Ready.
  2. Stall: HDU_Stall=1.
     - PC holds and StallCount increments.
     - If HDU_IFIDHold=1, IF/ID holds all fields.
     - Otherwise IF/ID reloads from the current fetch as in the normal case. Because PC is unchanged, this is idempotent.
  3. Memory not ready: IMem_Ready=0.
     - PC holds.
     - IF/ID loads a bubble unless HDU_IFIDHold=1, in which case it holds.
     - Counters are unchanged.
  4. Normal.
     - PC <= PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
     - IF/ID <= {IMem_Instr, PC+4, Valid=1}.
     - If HDU_IFIDHold=1 here (without HDU_Stall), IF/ID holds while PC still advances. This is a legal but unused combination; the bench checks it.
- IMem_Addr = PC, combinational.
- **Latency:** an instruction fetched at PC in cycle N appears on the IFID_* outputs in cycle N+1.
- **Rs/Rt outputs:**
  - Combinational from the IFID_Instr register, {27'b0, field}.
  - A bubble yields 0/0, so the hazard unit does not match against a stale instruction.
- **Counters:** saturate at all-ones and never wrap.
- No internal FSM beyond PC, the IF/ID register and the counters. All state is updated only on the clock edge, except for asynchronous reset.

Test Plan:
- Reset release, IMem_Ready=1, IMem returns 32'h8C22_0004 at PC 0 → cycle 1: PC=4, IFID_Instr=8C220004, IFID_PCPlus4=4, Valid=1, Rs=1, Rt=2. Assert Rst_n=0 mid-cycle → all outputs return to reset values immediately.
- HDU_Stall=HDU_IFIDHold=1 for 2 cycles at PC=8 → PC stays 8, IF/ID unchanged, StallCount=2. Deassert → PC=12 next edge.
- Branch_Taken=1, Branch_Target=32'h0000_0103, with HDU_Stall=1 the same cycle → PC=0x100, Valid=0, IFID_Instr=0, Rs=Rt=0, FlushCount=1, StallCount unchanged.
- Branch_Taken=Jump=1, targets 0x200/0x300 → PC=0x200, FlushCount increments once.
- IMem_Ready=0 for 3 cycles at PC=0x20 → PC holds at 0x20, Valid=0 each cycle. Ready returns → fetch at 0x20, PC=0x24.
- PC preset via redirect to 32'hFFFF_FFFC, then normal fetch → PC=0, IFID_PCPlus4=0. Force 2^CNT_W+5 stall cycles → StallCount=16'hFFFF.
